// File: rtl/bcd_timer_scan_pkg.sv
// Shared types for the BCD timer: control states, request priority encoding
// and the seven-segment decode table.
package bcd_timer_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      REQ_NONE,
      REQ_START,
      REQ_STOP,
      REQ_LOAD,
      REQ_CLEAR
   } req_e;

   // Index = BCD value, entry = {g,f,e,d,c,b,a}; codes 10..15 are dark.
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Only the highest-priority request of a cycle is acted upon.
   function automatic req_e encode_req(input logic clear_r, input logic load_r,
                                       input logic stop_r, input logic start_r);
      if (clear_r)      return REQ_CLEAR;
      else if (load_r)  return REQ_LOAD;
      else if (stop_r)  return REQ_STOP;
      else if (start_r) return REQ_START;
      return REQ_NONE;
   endfunction

endpackage

// File: rtl/bcd_timer_scan_digit.sv
// Single BCD up/down cell: synchronous clear/load (load saturates at 9) and
// a ripple carry/borrow out that is asserted when this cell rolls over.
module bcd_digit
   import bcd_timer_scan_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       step_i,
   input  logic       down_i,
   output logic [3:0] value_o,
   output logic       carry_o
);

   logic [3:0] value_q, value_d;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      value_d = value_q;
      if (clear_i) begin
         value_d = 4'd0;
      end else if (load_i) begin
         value_d = (load_val_i > 4'd9) ? 4'd9 : load_val_i;
      end else if (step_i) begin
         if (down_i) value_d = (value_q == 4'd0) ? 4'd9 : value_q - 4'd1;
         else        value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
      end
   end

   assign carry_o = step_i & (down_i ? (value_q == 4'd0) : (value_q == 4'd9));
   assign value_o = value_q;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) value_q <= 4'd0;
      else       value_q <= value_d;
   end

endmodule

// File: rtl/bcd_timer_scan.sv
// N-digit BCD up/down timer with start/stop/clear/load control and a
// multiplexed seven-segment scan driver. Option: BLANK_LEADING_ZERO_EN.
module bcd_timer_scan
   import bcd_timer_scan_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int TICK_DIV = 50_000_000,
   parameter int SCAN_DIV = 50_000,
   parameter int DP_POS   = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                clear,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                dir,
   output logic [4*DIGITS-1:0] digits,
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   com,
   output logic                running,
   output logic                tick,
   output logic                wrap_evt,
   output logic                zero_evt
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(TICK_DIV / 2);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

   state_e            state_q, state_d;
   logic              dir_q, dir_d;
   logic [TW-1:0]     pre_q, pre_d;
   logic              tick_q, tick_d;
   logic              wrap_q, wrap_d;
   logic              zero_q, zero_d;
   logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] com_q, com_d;

   req_e              req;
   logic              step;
   logic              dig_clear;
   logic              dig_load;
   logic              all_zero;
   logic              at_one;
   logic              top_carry;
   logic [IW-1:0]     idx_nxt;
   logic [3:0]        sel_digit;
   logic              dp_lit;
   logic [DIGITS-1:0] blank;

   assign req       = encode_req(clear, load, stop, start);
   assign dig_clear = (req == REQ_CLEAR);
   assign dig_load  = (req == REQ_LOAD);
   assign all_zero  = (digits == '0);
   assign at_one    = (digits == (4*DIGITS)'(1));

   // A start request while already running is ignored, so counting proceeds.
   assign step = (state_q == ST_RUN) && (req == REQ_NONE || req == REQ_START) &&
                 (pre_q == TICK_LAST);

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic cin;
      logic cout;
      if (k == 0) begin : g_lsd
         assign cin = step;
      end else begin : g_upper
         assign cin = g_digit[k-1].cout;
      end
      bcd_digit u_digit (
         .clk        (clk),
         .reset      (reset),
         .clear_i    (dig_clear),
         .load_i     (dig_load),
         .load_val_i (load_val[4*k +: 4]),
         .step_i     (cin),
         .down_i     (dir_q),
         .value_o    (digits[4*k +: 4]),
         .carry_o    (cout)
      );
   end
   assign top_carry = g_digit[DIGITS-1].cout;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pre_d   = pre_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      zero_d  = 1'b0;
      case (req)
         REQ_CLEAR, REQ_LOAD: begin
            state_d = ST_IDLE;
            pre_d   = '0;
         end
         REQ_STOP: if (state_q == ST_RUN) state_d = ST_PAUSE;
         REQ_START: begin
            if ((state_q == ST_IDLE || state_q == ST_PAUSE) && !(dir && all_zero)) begin
               state_d = ST_RUN;
               dir_d   = dir;
            end
         end
         default: ;
      endcase
      if (state_q == ST_RUN && (req == REQ_NONE || req == REQ_START)) begin
         if (step) begin
            pre_d  = '0;
            tick_d = 1'b1;
            wrap_d = !dir_q && top_carry;
            if (dir_q && at_one) begin
               state_d = ST_DONE;
               zero_d  = 1'b1;
            end
         end else begin
            pre_d = pre_q + TW'(1);
         end
      end
   end

`ifdef BLANK_LEADING_ZERO_EN
   // Digit k is dark when it and every digit above it are zero; digit 0 always shows.
   always_comb begin : p_blank
      logic zero_above;
      zero_above = 1'b1;
      blank      = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above && (digits[4*k +: 4] == 4'd0);
         blank[k]   = zero_above;
      end
   end
`else
   assign blank = '0;
`endif

   assign idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
   assign sel_digit = digits[4*idx_nxt +: 4];
   assign dp_lit    = (int'(idx_nxt) == DP_POS) &&
                      ((state_q == ST_RUN && pre_q < TICK_HALF) ||
                       state_q == ST_PAUSE || state_q == ST_DONE);

   // com and seg are loaded together on scan wrap so the pair never disagrees.
   always_comb begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      idx_d      = idx_q;
      seg_d      = seg_q;
      com_d      = com_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         idx_d      = idx_nxt;
         com_d      = ~(DIGITS'(1) << idx_nxt);
         seg_d      = {dp_lit, blank[idx_nxt] ? 7'd0 : SEG_LUT[sel_digit]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         dir_q      <= 1'b0;
         pre_q      <= '0;
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
         zero_q     <= 1'b0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_q      <= '0;
         com_q      <= '1;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         pre_q      <= pre_d;
         tick_q     <= tick_d;
         wrap_q     <= wrap_d;
         zero_q     <= zero_d;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         com_q      <= com_d;
      end
   end

   assign running  = (state_q == ST_RUN);
   assign tick     = tick_q;
   assign wrap_evt = wrap_q;
   assign zero_evt = zero_q;
   assign seg      = seg_q;
   assign com      = com_q;

endmodule
